// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: one data-memory transaction per instruction, 3+ cycles, stall_M holds the pipe until DONE.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses; otherwise the low address bits are cleared.
module lsu_mem_stage #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_M,
    input  logic        rd_en_M,
    input  logic [31:0] inst_M,
    input  logic [31:0] alu_out_M,
    input  logic [31:0] rdata2_M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] load_data_M,
    output logic        stall_M,
    output logic        lsu_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    logic [1:0]    state;
    logic [CW-1:0] tmo_cnt;
    logic [2:0]    ld_f3;
    logic [1:0]    ld_lane;
    logic [2:0]    funct3;
    logic          access;
    logic          f3_ok;
    logic          misalign;
    logic          reject;
    logic [1:0]    lane;
    logic [3:0]    wstrb_nxt;
    logic [31:0]   wdata_nxt;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_fmt;
    logic          unused_inst;

    assign funct3      = inst_M[14:12];
    assign access      = wr_en_M | rd_en_M;
    assign unused_inst = ^{inst_M[31:15], inst_M[11:0]};

    always_comb begin
        f3_ok = 1'b0;
        if (rd_en_M)
            f3_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        else
            f3_ok = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((funct3[1:0] == 2'b01) && alu_out_M[0]) ||
                      ((funct3[1:0] == 2'b10) && (alu_out_M[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign reject = (wr_en_M & rd_en_M) | ~f3_ok | misalign;

    // Lane already has the offending low bits cleared, so misaligned accesses land aligned.
    always_comb begin
        lane      = 2'b00;
        wstrb_nxt = 4'b1111;
        wdata_nxt = rdata2_M;
        case (funct3[1:0])
            2'b00: begin
                lane      = alu_out_M[1:0];
                wstrb_nxt = 4'b0001 << lane;
                wdata_nxt = {4{rdata2_M[7:0]}};
            end
            2'b01: begin
                lane      = {alu_out_M[1], 1'b0};
                wstrb_nxt = 4'b0011 << lane;
                wdata_nxt = {2{rdata2_M[15:0]}};
            end
            default: begin
                lane      = 2'b00;
                wstrb_nxt = 4'b1111;
                wdata_nxt = rdata2_M;
            end
        endcase
    end

    assign ld_byte = mem_rdata[{ld_lane, 3'b000} +: 8];
    assign ld_half = ld_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_fmt = mem_rdata;
        case (ld_f3)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = mem_rdata;
        endcase
    end

    // Gated by rst so an in-flight stall drops the instant reset asserts.
    assign stall_M = rst & (((state == IDLE) & access) | (state == REQ));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            ld_f3       <= 3'b000;
            ld_lane     <= 2'b00;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            mem_wstrb   <= 4'b0000;
            load_data_M <= 32'h0;
            lsu_err     <= 1'b0;
        end else begin
            lsu_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (reject) begin
                            state   <= DONE;
                            lsu_err <= 1'b1;
                        end else begin
                            state     <= REQ;
                            tmo_cnt   <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= wr_en_M;
                            mem_addr  <= {alu_out_M[31:2], 2'b00};
                            mem_wdata <= wr_en_M ? wdata_nxt : 32'h0;
                            mem_wstrb <= wr_en_M ? wstrb_nxt : 4'b0000;
                            ld_f3     <= funct3;
                            ld_lane   <= lane;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (!mem_we)
                            load_data_M <= ld_fmt;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        lsu_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: transaction-timeline model with a per-cycle compare process and literal pins.
module tb_lsu_mem_stage;
    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic        wr_en_M;
    logic        rd_en_M;
    logic [31:0] inst_M;
    logic [31:0] alu_out_M;
    logic [31:0] rdata2_M;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] load_data_M;
    logic        stall_M;
    logic        lsu_err;

    lsu_mem_stage #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .wr_en_M(wr_en_M), .rd_en_M(rd_en_M), .inst_M(inst_M),
        .alu_out_M(alu_out_M), .rdata2_M(rdata2_M), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .load_data_M(load_data_M), .stall_M(stall_M), .lsu_err(lsu_err)
    );

    // Expectations owned by the driver, checked by the compare process.
    int          test_id;
    logic        chk_en, exp_stall, exp_req, exp_err, exp_bus_en, exp_zero_bus, exp_we;
    logic [31:0] exp_load, exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        pin_en, pin_load_en, pin_bus_en;
    int          pin_stall, pin_req, pin_err;
    logic [31:0] pin_load, pin_addr, pin_wdata;
    logic [3:0]  pin_wstrb;

    int n_checks;
    int n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    function automatic logic model_issues(input logic we, input logic re, input logic [2:0] f3,
                                          input logic [31:0] addr);
        if (we && re) return 1'b0;
        if (re && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) return 1'b0;
        if (f3 == 3'd2 && addr[1:0] != 2'b00) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'd0) begin
            case (addr[1:0])
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (f3 == 3'd1) return addr[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (f3 == 3'd1) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rd);
        logic [7:0]  b [4];
        logic [15:0] h;
        for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
        h = addr[1] ? {b[3], b[2]} : {b[1], b[0]};
        case (f3)
            3'd0: return {{24{b[addr[1:0]][7]}}, b[addr[1:0]]};
            3'd4: return {24'h0, b[addr[1:0]]};
            3'd1: return {{16{h[15]}}, h};
            3'd5: return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: per-cycle model checks plus literal pins.
    initial begin
        int last_id, c_stall, c_req, c_err;
        last_id = -1; c_stall = 0; c_req = 0; c_err = 0;
        forever begin
            @(negedge clk);
            if (test_id != last_id) begin
                last_id = test_id; c_stall = 0; c_req = 0; c_err = 0;
            end
            if (chk_en) begin
                if (stall_M === 1'b1) c_stall++;
                if (mem_req === 1'b1) c_req++;
                if (lsu_err === 1'b1) c_err++;
                check("stall_M", 32'(stall_M), 32'(exp_stall));
                check("mem_req", 32'(mem_req), 32'(exp_req));
                check("lsu_err", 32'(lsu_err), 32'(exp_err));
                check("load_data_M", load_data_M, exp_load);
                if (exp_bus_en) begin
                    check("mem_we", 32'(mem_we), 32'(exp_we));
                    check("mem_addr", mem_addr, exp_addr);
                    check("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                    if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
                end
                if (exp_zero_bus) begin
                    check("rst_mem_we", 32'(mem_we), 32'h0);
                    check("rst_mem_addr", mem_addr, 32'h0);
                    check("rst_mem_wdata", mem_wdata, 32'h0);
                    check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
                end
            end
            if (pin_en) begin
                if (pin_stall >= 0) check("pin_stall_cycles", 32'(c_stall), 32'(pin_stall));
                if (pin_req >= 0) check("pin_req_cycles", 32'(c_req), 32'(pin_req));
                if (pin_err >= 0) check("pin_err_pulses", 32'(c_err), 32'(pin_err));
                if (pin_load_en) check("pin_load_data", load_data_M, pin_load);
            end
            if (pin_bus_en) begin
                check("pin_mem_addr", mem_addr, pin_addr);
                check("pin_mem_wstrb", 32'(mem_wstrb), 32'(pin_wstrb));
                check("pin_mem_wdata", mem_wdata, pin_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        pin_en = 1'b0;
        pin_bus_en = 1'b0;
    endtask

    task automatic pin(input int ps, input int pr, input int pe, input logic le, input logic [31:0] lv);
        step();
        pin_stall = ps; pin_req = pr; pin_err = pe; pin_load_en = le; pin_load = lv;
        pin_en = 1'b1;
    endtask

    task automatic run_access(input logic we, input logic re, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                              input int ack_at, input logic pb_en, input logic [31:0] pb_addr,
                              input logic [3:0] pb_wstrb, input logic [31:0] pb_wdata);
        int   r;
        logic acked;
        logic fin;
        step();
        test_id++;
        wr_en_M = we; rd_en_M = re; inst_M = {17'h0, f3, 12'h003};
        alu_out_M = addr; rdata2_M = wd; mem_rdata = rd; mem_ack = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0; exp_bus_en = 1'b0; exp_zero_bus = 1'b0;
        if (!model_issues(we, re, f3, addr)) begin
            step();
            exp_stall = 1'b0; exp_err = 1'b1;
        end else begin
            r = 0; acked = 1'b0; fin = 1'b0;
            while (!fin) begin
                step();
                r++;
                exp_req = 1'b1; exp_stall = 1'b1; exp_bus_en = 1'b1; exp_we = we;
                exp_addr = {addr[31:2], 2'b00};
                exp_wstrb = we ? model_wstrb(f3, addr) : 4'b0000;
                exp_wdata = model_wdata(f3, wd);
                mem_ack = (r == ack_at) ? 1'b1 : 1'b0;
                if (r == 1 && pb_en) begin
                    pin_addr = pb_addr; pin_wstrb = pb_wstrb; pin_wdata = pb_wdata; pin_bus_en = 1'b1;
                end
                if (r == ack_at) acked = 1'b1;
                if (acked || r == TMO) fin = 1'b1;
            end
            step();
            mem_ack = 1'b0;
            exp_req = 1'b0; exp_stall = 1'b0; exp_bus_en = 1'b0; exp_err = !acked;
            if (acked && re) exp_load = model_load(f3, addr, rd);
        end
        step();
        wr_en_M = 1'b0; rd_en_M = 1'b0;
        exp_stall = 1'b0; exp_err = 1'b0; exp_req = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_err = 0; test_id = 0;
        rst = 1'b0; wr_en_M = 1'b0; rd_en_M = 1'b0; inst_M = 32'h0; alu_out_M = 32'h0;
        rdata2_M = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        chk_en = 1'b1; exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_load = 32'h0;
        exp_bus_en = 1'b0; exp_zero_bus = 1'b1; exp_we = 1'b0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_wstrb = 4'h0;
        pin_en = 1'b0; pin_load_en = 1'b0; pin_bus_en = 1'b0;
        pin_stall = -1; pin_req = -1; pin_err = -1;
        pin_load = 32'h0; pin_addr = 32'h0; pin_wdata = 32'h0; pin_wstrb = 4'h0;
        step();
        step();
        rst = 1'b1;
        step();

        // LW 0x100, ack in second request cycle
        run_access(1'b0, 1'b1, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0, 32'h0, 4'h0, 32'h0);
        pin(3, 2, 0, 1'b1, 32'hDEADBEEF);
        // LB / LBU lane 3
        run_access(1'b0, 1'b1, 3'd0, 32'h103, 32'h0, 32'h80112233, 1, 1'b0, 32'h0, 4'h0, 32'h0);
        pin(2, 1, 0, 1'b1, 32'hFFFFFF80);
        run_access(1'b0, 1'b1, 3'd4, 32'h103, 32'h0, 32'h80112233, 1, 1'b0, 32'h0, 4'h0, 32'h0);
        pin(2, 1, 0, 1'b1, 32'h00000080);
        // LH upper half, LHU lower half
        run_access(1'b0, 1'b1, 3'd1, 32'h102, 32'h0, 32'h80112233, 1, 1'b0, 32'h0, 4'h0, 32'h0);
        pin(-1, -1, -1, 1'b1, 32'hFFFF8011);
        run_access(1'b0, 1'b1, 3'd5, 32'h100, 32'h0, 32'h80112233, 3, 1'b0, 32'h0, 4'h0, 32'h0);
        pin(4, 3, 0, 1'b1, 32'h00002233);
        // Stores
        run_access(1'b1, 1'b0, 3'd1, 32'h102, 32'h0000ABCD, 32'h0, 1, 1'b1, 32'h100, 4'b1100, 32'hABCDABCD);
        run_access(1'b1, 1'b0, 3'd0, 32'h001, 32'h123456A5, 32'h0, 3, 1'b1, 32'h0, 4'b0010, 32'hA5A5A5A5);
        pin(4, 3, 0, 1'b1, 32'h00002233);
        run_access(1'b1, 1'b0, 3'd2, 32'h010, 32'hCAFEF00D, 32'h0, 1, 1'b1, 32'h10, 4'b1111, 32'hCAFEF00D);
        // Rejected accesses
        run_access(1'b1, 1'b1, 3'd2, 32'h200, 32'h1, 32'h0, 1, 1'b0, 32'h0, 4'h0, 32'h0);
        pin(1, 0, 1, 1'b1, 32'h00002233);
        run_access(1'b0, 1'b1, 3'd3, 32'h200, 32'h0, 32'h5555AAAA, 1, 1'b0, 32'h0, 4'h0, 32'h0);
        pin(1, 0, 1, 1'b0, 32'h0);
        run_access(1'b1, 1'b0, 3'd4, 32'h200, 32'h0, 32'h0, 1, 1'b0, 32'h0, 4'h0, 32'h0);
        // Timeout: no ack ever
        run_access(1'b0, 1'b1, 3'd2, 32'h300, 32'h0, 32'h77777777, 0, 1'b0, 32'h0, 4'h0, 32'h0);
        pin(17, 16, 1, 1'b1, 32'h00002233);
        // Misaligned SW at 0x101
`ifdef LSU_MISALIGN_TRAP_EN
        run_access(1'b1, 1'b0, 3'd2, 32'h101, 32'h01020304, 32'h0, 1, 1'b0, 32'h0, 4'h0, 32'h0);
        pin(1, 0, 1, 1'b0, 32'h0);
`else
        run_access(1'b1, 1'b0, 3'd2, 32'h101, 32'h01020304, 32'h0, 1, 1'b1, 32'h100, 4'b1111, 32'h01020304);
        pin(2, 1, 0, 1'b0, 32'h0);
`endif

        // Reset asserted mid-request, then a stale ack while idle
        step();
        test_id++;
        rd_en_M = 1'b1; wr_en_M = 1'b0; inst_M = {17'h0, 3'd2, 12'h003};
        alu_out_M = 32'h200; mem_rdata = 32'h0BADF00D;
        exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0; exp_bus_en = 1'b0;
        step();
        exp_req = 1'b1; exp_bus_en = 1'b1; exp_we = 1'b0; exp_addr = 32'h200; exp_wstrb = 4'b0000;
        step();
        rst = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_bus_en = 1'b0; exp_zero_bus = 1'b1; exp_load = 32'h0;
        step();
        rd_en_M = 1'b0;
        step();
        rst = 1'b1;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        pin(-1, 1, 0, 1'b1, 32'h0);
        run_access(1'b0, 1'b1, 3'd2, 32'h104, 32'h0, 32'h13579BDF, 1, 1'b0, 32'h0, 4'h0, 32'h0);
        pin(2, 1, 0, 1'b1, 32'h13579BDF);

        step();
        step();
        chk_en = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
